// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state encoding for the UART transmit arbiter
package uart_tx_arbiter_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_SETTLE,
    ST_WAIT,
    ST_GAP
  } state_e;
endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: one-hot round-robin pick searching upward from last+1
module rr_select #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);
  // scan from lowest to highest priority so the closest match after last overwrites the rest
  always_comb begin
    gnt = '0;
    gnt_idx = last;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(last) + i) % N]) begin
        gnt = '0;
        gnt[(int'(last) + i) % N] = 1'b1;
        gnt_idx = W'((int'(last) + i) % N);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between byte-stream clients
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CLIENTS-1:0]   req_valid,
  input  logic [8*NUM_CLIENTS-1:0] req_data,
  input  logic [NUM_CLIENTS-1:0]   req_last,
  output logic [NUM_CLIENTS-1:0]   req_ready,
  input  logic                     tx_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [NUM_CLIENTS-1:0]   grant,
  output logic                     busy
);
  localparam int W = $clog2(NUM_CLIENTS);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_e state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d, sel_gnt;
  logic [W-1:0] last_winner_q, last_winner_d, sel_idx;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_start_q, tx_start_d, last_flag_q, last_flag_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  rr_select #(.N(NUM_CLIENTS), .W(W)) u_rr (
    .req(req_valid),
    .last(last_winner_q),
    .gnt(sel_gnt),
    .gnt_idx(sel_idx)
  );
  assign req_ready = state_q == ST_LOAD ? grant_q : '0;
  assign tx_start = tx_start_q;
  assign tx_data = tx_data_q;
  assign grant = grant_q;
  assign busy = state_q != ST_IDLE;
  // next-state logic; last_winner doubles as the owner index while a message is in flight
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_winner_d = last_winner_q;
    tx_data_d = tx_data_q;
    tx_start_d = 1'b0;
    last_flag_d = last_flag_q;
    gap_cnt_d = '0;
    case (state_q)
      ST_IDLE: if (|req_valid && tx_ready) begin
        state_d = ST_LOAD;
        grant_d = sel_gnt;
        last_winner_d = sel_idx;
      end
      ST_LOAD: if (req_valid[last_winner_q]) begin
        tx_data_d = req_data[8*last_winner_q +: 8];
        last_flag_d = req_last[last_winner_q];
        tx_start_d = 1'b1;
        state_d = ST_FIRE;
      end
      ST_FIRE: state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: if (tx_ready) begin
        state_d = !last_flag_q ? ST_LOAD : GAP_CYCLES > 0 ? ST_GAP : ST_IDLE;
        grant_d = last_flag_q ? '0 : grant_q;
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q == GAP_LAST ? '0 : gap_cnt_q + 1'b1;
        state_d = gap_cnt_q == GAP_LAST ? ST_IDLE : ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state registers; client 0 wins first after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_winner_q <= W'(NUM_CLIENTS - 1);
      tx_data_q <= '0;
      tx_start_q <= 1'b0;
      last_flag_q <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_winner_q <= last_winner_d;
      tx_data_q <= tx_data_d;
      tx_start_q <= tx_start_d;
      last_flag_q <= last_flag_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CLIENTS, default 2, range 2..8: number of byte-stream requesters sharing one UART transmitter.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 0: idle clocks inserted after each completed message; 0 means no gap.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  NUM_CLIENTS  per-client byte available.
REQ-006 req_data  in  8*NUM_CLIENTS  per-client byte; client i uses bits [8*i +: 8].
REQ-007 req_last  in  NUM_CLIENTS  marks the final byte of the client's message.
REQ-008 req_ready  out  NUM_CLIENTS  byte accepted when valid and ready are both high in the same cycle.
REQ-009 tx_ready  in  1  UART transmitter idle (high = idle).
REQ-010 tx_start  out  1  one-cycle, registered transmit strobe.
REQ-011 tx_data  out  8  byte to transmit; registered, stable from tx_start until the next accept.
REQ-012 grant  out  NUM_CLIENTS  one-hot current owner; all zeros when no owner.
REQ-013 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, FIRE, SETTLE, WAIT and GAP.
REQ-015 IDLE: if any req_valid bit is set and tx_ready=1, the FSM SHALL grant the first requesting client searching upward from (last_winner+1) mod NUM_CLIENTS, update last_winner, and go to LOAD; otherwise it stays in IDLE.
REQ-016 LOAD: req_ready[owner] SHALL be combinationally high only in LOAD; on valid&ready it SHALL capture tx_data, capture req_last into last_flag, and go to FIRE; otherwise it stays in LOAD with the grant held.
REQ-017 FIRE: tx_start SHALL be high for exactly this one cycle; the next state is SETTLE.
REQ-018 SETTLE: tx_ready SHALL be ignored for this one cycle; the next state is WAIT.
REQ-019 WAIT: when tx_ready=1, the FSM SHALL go to LOAD if last_flag=0; if last_flag=1 it SHALL clear grant and go to GAP (GAP_CYCLES>0) or to IDLE (GAP_CYCLES=0).
REQ-020 GAP: the counter SHALL run 0..GAP_CYCLES-1 and return to IDLE after exactly GAP_CYCLES cycles; the counter SHALL be held at 0 outside GAP.
REQ-021 Latency: a request sampled in IDLE with valid already high SHALL produce tx_start 2 cycles later; accept-to-tx_start SHALL be 1 cycle.
REQ-022 A grant SHALL never change mid-message; other clients' req_ready SHALL stay 0 until the owner's last byte completes.
REQ-023 If the owner drops req_valid mid-message, the block SHALL wait in LOAD indefinitely without timeout or preemption.
REQ-024 Simultaneous requests SHALL resolve round-robin, so every client is served within NUM_CLIENTS messages.
REQ-025 A single-byte message (req_last=1 on the first byte) SHALL be legal.
REQ-026 A new request arriving during WAIT, GAP or SETTLE SHALL be ignored until IDLE.

Reset
REQ-027 On rst=1 at a clock edge, the FSM SHALL enter IDLE and tx_start=0, tx_data=0, grant=0, busy=0, last_flag=0, gap counter=0, last_winner=NUM_CLIENTS-1 (client 0 wins first).
REQ-028 Reset asserted mid-message SHALL abort the message: no further tx_start or req_ready, and the aborted client receives no indication.

Structure
REQ-029 The FSM state encodings SHALL be localparams in a shared include alongside baudgen.vh (uart_arb.vh); clog2 sizing SHALL be done locally.
REQ-030 The round-robin priority selector (request vector and last_winner in, one-hot winner out, combinational) SHALL be one sub-module, rr_select.
REQ-031 The UART transmitter itself SHALL be instantiated outside this block.

Verification
REQ-032 Single client, 3-byte message 0x41,0x42,0x43 with last on 0x43, and a tx_ready model busy 10 cycles per byte -> 3 tx_start pulses with tx_data 0x41/0x42/0x43 in order, then grant=0.
REQ-033 Both clients valid in the same cycle after reset -> client 0 is served first, client 1 next, then client 0 again on a repeat request.
REQ-034 Client 1 requests while client 0 is mid-message -> req_ready[1]=0 until client 0's last byte completes, with no interleaved bytes.
REQ-035 GAP_CYCLES=5 -> exactly 5 cycles of busy=1 with grant=0 between the last byte's tx_ready and the next IDLE grant.
REQ-036 rst pulsed during WAIT of byte 2 -> next cycle all outputs are 0; a new request is re-arbitrated with client 0 first.
REQ-037 Owner drops valid for 20 cycles mid-message -> FSM holds LOAD, no tx_start, and resumes on revalid.
